// File: rtl/param_val_rotator_pkg.sv
// Shared encodings for the parameterised value rotator: FSM states and mode selects.
package param_val_rotator_pkg;

    localparam logic [1:0] StEmpty = 2'b00;
    localparam logic [1:0] StRun   = 2'b01;
    localparam logic [1:0] StPause = 2'b10;

    localparam logic [1:0] ModeHold     = 2'b00;
    localparam logic [1:0] ModeLeft     = 2'b01;
    localparam logic [1:0] ModeRight    = 2'b10;
    localparam logic [1:0] ModePingpong = 2'b11;

endpackage

// File: rtl/rate_prescaler.sv
// Free-running 0..DIV-1 counter; tick marks the last count of each period while run is high.
module rate_prescaler #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = run && (cnt_q == CntMax);

    // Count is held, not cleared, while run is low so a pause resumes mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/param_val_rotator.sv
// Loadable value rotator: rotates out_val by STEP bits every DIV cycles (left, right or ping-pong).
module param_val_rotator
    import param_val_rotator_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 1,
    parameter int unsigned DIV   = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out_val,
    output logic             tick,
    output logic             wrap,
    output logic             loaded
);

    localparam int unsigned Steps = WIDTH / STEP;
    localparam int unsigned StepW = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [StepW-1:0] StepLast = StepW'(Steps - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] val_q;
    logic [StepW-1:0] step_q;
    logic             dir_q;     // 0 = left, 1 = right (ping-pong only)
    logic             tick_q, wrap_q, loaded_q;

    logic             active;
    logic             strobe;
    logic             rotate;
    logic             go_left;
    logic             last_step;
    logic [WIDTH-1:0] rot_val;

    // Load takes priority over a coincident rotation edge.
    assign active    = (state_q == StRun) && en && (mode != ModeHold) && !load;
    assign rotate    = active && strobe;
    assign last_step = (step_q == StepLast);
    assign go_left   = (mode == ModeLeft) || ((mode == ModePingpong) && !dir_q);

    rate_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (active),
        .clr  (load),
        .tick (strobe)
    );

    always_comb begin
        rot_val = go_left ? ((val_q << STEP) | (val_q >> (WIDTH - STEP)))
                          : ((val_q >> STEP) | (val_q << (WIDTH - STEP)));
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = en ? StRun : StPause;
        end else begin
            case (state_q)
                StEmpty: state_d = StEmpty;
                StRun:   if (!en || (mode == ModeHold)) state_d = StPause;
                StPause: if (en && (mode != ModeHold)) state_d = StRun;
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StEmpty;
            val_q    <= '0;
            step_q   <= '0;
            dir_q    <= 1'b0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= rotate;
            wrap_q  <= rotate && last_step;
            if (load) begin
                val_q    <= load_val;
                step_q   <= '0;
                dir_q    <= 1'b0;
                loaded_q <= 1'b1;
            end else if (rotate) begin
                val_q  <= rot_val;
                step_q <= last_step ? '0 : step_q + 1'b1;
                if (last_step) begin
                    dir_q <= ~dir_q;
                end
            end
        end
    end

    assign out_val = val_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign loaded  = loaded_q;

endmodule

// File: tb/tb_param_val_rotator.sv
// Directed plus randomized bench for param_val_rotator (WIDTH=8, STEP=1, DIV=4).
module tb_param_val_rotator;

    localparam int W = 8;
    localparam int S = 1;
    localparam int D = 4;
    localparam int N = W / S;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] out_val;
    logic         tick;
    logic         wrap;
    logic         loaded;

    int checks = 0;
    int failures = 0;

    // Reference model state: 0 empty, 1 run, 2 pause.
    int           m_st;
    int           m_cnt;
    int           m_steps;
    bit           m_right;
    bit           m_loaded;
    bit           m_tick;
    bit           m_wrap;
    logic [W-1:0] m_val;

    param_val_rotator #(
        .WIDTH (W),
        .STEP  (S),
        .DIV   (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .mode     (mode),
        .out_val  (out_val),
        .tick     (tick),
        .wrap     (wrap),
        .loaded   (loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rotate_bits(input logic [W-1:0] v, input bit right);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (right) r[i] = v[(i + S) % W];
            else       r[(i + S) % W] = v[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_steps = 0; m_right = 0;
        m_loaded = 0; m_tick = 0; m_wrap = 0; m_val = '0;
    endtask

    // Advance the model by one clock edge given the inputs present before it.
    task automatic model_step(input bit l, input logic [W-1:0] v, input bit e,
                              input logic [1:0] m);
        bit counting;
        bit right;
        counting = (m_st == 1) && e && (m != 2'b00) && !l;
        m_tick = counting && (m_cnt == D - 1);
        m_wrap = m_tick && (m_steps == N - 1);
        right  = (m == 2'b10) || ((m == 2'b11) && m_right);
        if (l) begin
            m_val = v; m_cnt = 0; m_steps = 0; m_right = 0; m_loaded = 1;
        end else if (counting) begin
            m_cnt = (m_cnt + 1) % D;
            if (m_tick) begin
                m_val   = rotate_bits(m_val, right);
                m_steps = (m_steps + 1) % N;
                if (m_wrap) m_right = !m_right;
            end
        end
        if (l)                                     m_st = e ? 1 : 2;
        else if (m_st == 1 && (!e || m == 2'b00))  m_st = 2;
        else if (m_st == 2 && e && m != 2'b00)     m_st = 1;
    endtask

    task automatic cyc(input bit l, input logic [W-1:0] v, input bit e, input logic [1:0] m);
        load = l; load_val = v; en = e; mode = m;
        model_step(l, v, e, m);
        @(posedge clk);
        #1;
        check("out_val", 32'(out_val), 32'(m_val));
        check("tick", 32'(tick), 32'(m_tick));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("loaded", 32'(loaded), 32'(m_loaded));
    endtask

    task automatic run(input int n, input bit e, input logic [1:0] m);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, e, m);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; mode = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out", 32'(out_val), 32'h0);
        check("reset_loaded", 32'(loaded), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);

        // EMPTY ignores en/mode
        run(6, 1'b1, 2'b01);
        check("empty_out", 32'(out_val), 32'h0);

        // Rotate left from 0x81
        cyc(1'b1, 8'h81, 1'b1, 2'b01);
        run(3, 1'b1, 2'b01);
        check("left_pre", 32'(out_val), 32'h81);
        cyc(1'b0, '0, 1'b1, 2'b01);
        check("left_first", 32'(out_val), 32'h03);
        check("left_tick", 32'(tick), 32'h1);
        cyc(1'b0, '0, 1'b1, 2'b01);
        check("tick_one_cycle", 32'(tick), 32'h0);
        run(27, 1'b1, 2'b01);
        check("left_wrap_val", 32'(out_val), 32'h81);
        check("left_wrap", 32'(wrap), 32'h1);

        // Rotate right from 0x81
        cyc(1'b1, 8'h81, 1'b1, 2'b10);
        run(4, 1'b1, 2'b10);
        check("right_first", 32'(out_val), 32'hC0);
        run(4, 1'b1, 2'b10);
        check("right_second", 32'(out_val), 32'h60);

        // Ping-pong: eight lefts, then direction flips
        cyc(1'b1, 8'h01, 1'b1, 2'b11);
        run(32, 1'b1, 2'b11);
        check("pp_wrap_val", 32'(out_val), 32'h01);
        check("pp_wrap", 32'(wrap), 32'h1);
        run(4, 1'b1, 2'b11);
        check("pp_right", 32'(out_val), 32'h80);

        // Pause after two prescaler counts, then resume
        cyc(1'b1, 8'h81, 1'b1, 2'b01);
        run(2, 1'b1, 2'b01);
        run(10, 1'b0, 2'b01);
        check("pause_frozen", 32'(out_val), 32'h81);
        run(3, 1'b1, 2'b01);
        check("resume_rot", 32'(out_val), 32'h03);
        check("resume_tick", 32'(tick), 32'h1);

        // Load on a rotation-edge cycle wins
        cyc(1'b1, 8'h81, 1'b1, 2'b01);
        run(3, 1'b1, 2'b01);
        cyc(1'b1, 8'h55, 1'b1, 2'b01);
        check("load_win_val", 32'(out_val), 32'h55);
        check("load_win_tick", 32'(tick), 32'h0);
        run(3, 1'b1, 2'b01);
        check("load_win_hold", 32'(out_val), 32'h55);
        cyc(1'b0, '0, 1'b1, 2'b01);
        check("load_win_next", 32'(out_val), 32'hAA);

        // Randomized traffic against the model
        mode = 2'b01;
        for (int i = 0; i < 400; i++) begin
            logic [1:0] m;
            m = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : mode;
            cyc(($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 7) != 0), m);
        end

        // Asynchronous reset mid-run
        cyc(1'b1, 8'hA5, 1'b1, 2'b01);
        run(5, 1'b1, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("async_out", 32'(out_val), 32'h0);
        check("async_loaded", 32'(loaded), 32'h0);
        check("async_tick", 32'(tick), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(12, 1'b1, 2'b01);
        check("post_rst_out", 32'(out_val), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
